// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and helpers shared by the sequential ALU.
package alu_seq_pkg;
  localparam logic [1:0] OP_SUB        = 2'd0;
  localparam logic [1:0] OP_NAND       = 2'd1;
  localparam logic [1:0] OP_LEAD_ONES  = 2'd2;
  localparam logic [1:0] OP_ONEHOT_DEC = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  // True when n does not fit in w unsigned bits, i.e. n > 2^w-1.
  function automatic logic exceeds(input int unsigned n, input int unsigned w);
    return (n >> w) != 0;
  endfunction
endpackage

// File: rtl/alu_seq_lead_ones_scanner.sv
// lead_ones_scanner: serial MSB-first leading-ones counter, one bit per cycle.
module lead_ones_scanner #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(2*WIDTH+1),
  localparam int IW = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] vector,
  output logic               done,
  output logic [CW-1:0]      count
);
  logic          active;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  // done and count describe the bit inspected this cycle, so the caller can register the final count directly.
  assign done  = active & (~vector[idx] | (idx == '0));
  assign count = cnt + CW'(vector[idx]);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      idx    <= IW'(2*WIDTH-1);
      cnt    <= '0;
    end else if (active) begin
      active <= ~done;
      idx    <= idx - 1'b1;
      cnt    <= count;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with registered result and sticky overflow/error flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_overflow,
  output logic             o_err,
  input  logic             i_clr_flags,
  output logic             o_sticky_ovf,
  output logic             o_sticky_err
);
  localparam int CW = $clog2(2*WIDTH+1);
  state_t             state, next;
  logic [2*WIDTH-1:0] v, v_q;
  logic [CW-1:0]      pos, count;
  logic [WIDTH-1:0]   diff, ry;
  logic               rovf, rerr, accept, deliver, done;
  assign v       = {i_b, i_a};
  assign o_ready = (state == ST_IDLE) && !i_rst;
  assign accept  = i_valid & o_ready;
  assign o_valid = state == ST_DONE;
  assign deliver = o_valid & i_ready;
  lead_ones_scanner #(.WIDTH(WIDTH)) u_scan (
    .clk(i_clk), .rst(i_rst), .start(accept && i_op == OP_LEAD_ONES),
    .vector(v_q), .done(done), .count(count)
  );
  // Scan downward so the last hit is the lowest set bit; all-zero leaves pos=0.
  always_comb begin
    pos = '0;
    for (int i = 2*WIDTH-1; i >= 0; i--)
      if (v[i]) pos = CW'(i);
  end
  always_comb begin
    diff = i_a - i_b;
    ry   = i_op == OP_SUB ? diff : i_op == OP_NAND ? ~(i_a & i_b) : WIDTH'(pos);
    rovf = i_op == OP_SUB ? (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1])
         : i_op == OP_ONEHOT_DEC ? exceeds(32'(pos), WIDTH) : 1'b0;
    rerr = (i_op == OP_ONEHOT_DEC) && ($countones(v) != 1);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= ST_IDLE;
    else       state <= next;
  always_comb begin
    next = state;
    next = state == ST_IDLE ? (accept ? (i_op == OP_LEAD_ONES ? ST_BUSY : ST_DONE) : ST_IDLE)
         : state == ST_BUSY ? (done ? ST_DONE : ST_BUSY)
         : (i_ready ? ST_IDLE : ST_DONE);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      v_q          <= '0;
      o_y          <= '0;
      o_overflow   <= 1'b0;
      o_err        <= 1'b0;
      o_sticky_ovf <= 1'b0;
      o_sticky_err <= 1'b0;
    end else begin
      if (accept) v_q <= v;
      if (accept && i_op != OP_LEAD_ONES) {o_y, o_overflow, o_err} <= {ry, rovf, rerr};
      else if (state == ST_BUSY && done) {o_y, o_overflow, o_err} <= {WIDTH'(count), exceeds(32'(count), WIDTH), 1'b0};
      // A delivery in the same cycle as a clear keeps the flag set.
      o_sticky_ovf <= (deliver & o_overflow) | (o_sticky_ovf & ~i_clr_flags);
      o_sticky_err <= (deliver & o_err) | (o_sticky_err & ~i_clr_flags);
    end
endmodule
